// File: rtl/instruction_fetch_if.sv
// Fetch-to-decode stream: one instruction and its byte PC per valid/ready handshake.
interface instruction_fetch_if;
    logic [31:0] instruction;
    logic        is_instruction_valid;
    logic [31:0] pc;
    logic        decode_ready;

    modport master (output instruction, is_instruction_valid, pc, input decode_ready);
    modport slave  (input instruction, is_instruction_valid, pc, output decode_ready);
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: word-addressed instruction memory, PC stepper and a 2-entry output buffer
// that hides the 1-cycle memory read latency from the downstream valid/ready stream.
//
// state | meaning
// IDLE  | after reset, memory preload allowed, waiting for start
// FETCH | issuing reads and pushing returned words into the buffer
// DRAIN | no more reads; emptying the buffer
// DONE  | program finished, preload allowed, start restarts from PC 0
module instruction_fetch #(
    parameter int MEM_DEPTH = 64,
    parameter int ADDR_W    = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      imem_we,
    input  logic [ADDR_W-1:0]         imem_addr,
    input  logic [31:0]               imem_wdata,
    instruction_fetch_if.master       fetch,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] mem [MEM_DEPTH];
    logic [31:0] rdata;
    logic [31:0] rd_pc;
    logic [31:0] fetch_pc;
    logic        inflight;
    logic        end_reached;
    logic [31:0] buf_instr [2];
    logic [31:0] buf_pc [2];
    logic [1:0]  count;
    logic [2:0]  occ;
    logic        idle_like, pop, push, term, issue, wr_hi, restart;

    assign idle_like = (state == IDLE) || (state == DONE);
    assign restart   = idle_like && start;
    assign pop       = (count != 2'd0) && fetch.decode_ready;
    assign push      = inflight && (rdata != 32'h0);
    assign term      = inflight && (rdata == 32'h0);
    assign occ       = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    // A terminator returning this cycle squashes the read that would otherwise issue.
    assign issue     = (state == FETCH) && !end_reached && !term && (occ < 3'd2);
    assign wr_hi     = (count - {1'b0, pop}) == 2'd1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = FETCH;
            FETCH: begin
                if (term)                         state_nxt = DRAIN;
                else if (end_reached && !inflight) state_nxt = DRAIN;
            end
            DRAIN: if ((count == 2'd0) && !inflight) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (imem_we && idle_like) mem[imem_addr] <= imem_wdata;
        if (issue)                rdata <= mem[fetch_pc[ADDR_W+1:2]];
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            buf_instr[0] <= buf_instr[1];
            buf_pc[0]    <= buf_pc[1];
        end
        // Later assignment wins when a pop and a push both land in slot 0.
        if (push) begin
            buf_instr[wr_hi] <= rdata;
            buf_pc[wr_hi]    <= rd_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= 2'd0;
            inflight    <= 1'b0;
            end_reached <= 1'b0;
            fetch_pc    <= 32'h0;
            rd_pc       <= 32'h0;
        end else begin
            state <= state_nxt;
            if (restart) begin
                count       <= 2'd0;
                inflight    <= 1'b0;
                end_reached <= 1'b0;
                fetch_pc    <= 32'h0;
            end else begin
                inflight <= issue;
                count    <= count + {1'b0, push} - {1'b0, pop};
                if (issue) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    rd_pc    <= fetch_pc;
                    if (fetch_pc[ADDR_W+1:2] == ADDR_W'(MEM_DEPTH - 1)) end_reached <= 1'b1;
                end
            end
        end
    end

    assign fetch.is_instruction_valid = (count != 2'd0);
    assign fetch.instruction          = (count != 2'd0) ? buf_instr[0] : 32'h0;
    assign fetch.pc                   = (count != 2'd0) ? buf_pc[0] : 32'h0;
    assign busy                       = (state == FETCH) || (state == DRAIN);
    assign done                       = (state == DONE);

endmodule
